// File: rtl/cordic_pipe_engine.sv
// Fully pipelined CORDIC engine for Givens-rotation QR.
// One micro-rotation per registered stage; vectoring, rotation and follow
// (replay of recorded direction bits) modes, with a valid/ready stream,
// global stall and a pass-through tag.
module cordic_pipe_engine #(
    parameter int DATA_W = 17,
    parameter int ANG_W  = 16,
    parameter int STAGES = 12,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [DATA_W-1:0]   in_x,
    input  logic [DATA_W-1:0]   in_y,
    input  logic [ANG_W-1:0]    in_ang,
    input  logic [STAGES-1:0]   in_mu,
    input  logic                in_mu_inv,
    input  logic                in_bypass,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_x,
    output logic [DATA_W-1:0]   out_y,
    output logic [ANG_W-1:0]    out_ang,
    output logic [STAGES-1:0]   out_mu,
    output logic                out_zero,
    output logic [TAG_W-1:0]    out_tag
);

    typedef enum logic [1:0] {
        MODE_VEC = 2'b00,
        MODE_ROT = 2'b01,
        MODE_FOL = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    // Elementary angles atan(2^-i) in units of 2^-14 rad, scaled to ANG_W.
    function automatic logic signed [ANG_W-1:0] elem_ang(input int unsigned i);
        logic [15:0] t;
        case (i)
            0:       t = 16'd12867;
            1:       t = 16'd7596;
            2:       t = 16'd4013;
            3:       t = 16'd2037;
            4:       t = 16'd1022;
            5:       t = 16'd511;
            6:       t = 16'd255;
            7:       t = 16'd127;
            8:       t = 16'd63;
            9:       t = 16'd31;
            10:      t = 16'd15;
            11:      t = 16'd7;
            12:      t = 16'd3;
            13:      t = 16'd1;
            default: t = 16'd0;
        endcase
        return $signed(ANG_W'(t >> (16 - ANG_W)));
    endfunction

    // Stage registers
    logic signed [DATA_W-1:0] x_q     [STAGES];
    logic signed [DATA_W-1:0] y_q     [STAGES];
    logic signed [ANG_W-1:0]  ang_q   [STAGES];
    mode_e                    mode_q  [STAGES];
    logic                     inv_q   [STAGES];
    logic                     byp_q   [STAGES];
    logic                     zero_q  [STAGES];
    logic                     v_q     [STAGES];
    logic [TAG_W-1:0]         tag_q   [STAGES];
    logic [STAGES-1:0]        murec_q [STAGES];
    logic [STAGES-1:0]        mu_q    [STAGES];

    // Next-state values
    logic signed [DATA_W-1:0] x_d     [STAGES];
    logic signed [DATA_W-1:0] y_d     [STAGES];
    logic signed [ANG_W-1:0]  ang_d   [STAGES];
    mode_e                    mode_d  [STAGES];
    logic                     inv_d   [STAGES];
    logic                     byp_d   [STAGES];
    logic                     zero_d  [STAGES];
    logic                     v_d     [STAGES];
    logic [TAG_W-1:0]         tag_d   [STAGES];
    logic [STAGES-1:0]        murec_d [STAGES];
    logic [STAGES-1:0]        mu_d    [STAGES];

    // Per-stage operand sources (input port for stage 0, previous stage otherwise)
    logic signed [DATA_W-1:0] s_x     [STAGES];
    logic signed [DATA_W-1:0] s_y     [STAGES];
    logic signed [ANG_W-1:0]  s_ang   [STAGES];
    mode_e                    s_mode  [STAGES];
    logic                     s_inv   [STAGES];
    logic                     s_byp   [STAGES];
    logic                     s_zero  [STAGES];
    logic                     s_v     [STAGES];
    logic [TAG_W-1:0]         s_tag   [STAGES];
    logic [STAGES-1:0]        s_murec [STAGES];
    logic [STAGES-1:0]        s_mu    [STAGES];

    logic en;

    assign en       = !v_q[STAGES-1] || out_ready;
    assign in_ready = en;

    // Route each stage's operands: the input beat into stage 0, stage i-1 into stage i
    always_comb begin
        s_x[0]     = $signed(in_x);
        s_y[0]     = $signed(in_y);
        s_ang[0]   = (in_mode == MODE_ROT) ? $signed(in_ang) : '0;
        s_mode[0]  = mode_e'(in_mode);
        s_inv[0]   = in_mu_inv;
        s_byp[0]   = in_bypass;
        s_zero[0]  = (in_mode == MODE_VEC) && (in_x == '0) && (in_y == '0);
        s_v[0]     = in_valid;
        s_tag[0]   = in_tag;
        s_murec[0] = in_mu;
        s_mu[0]    = '0;
        for (int unsigned i = 1; i < STAGES; i++) begin
            s_x[i]     = x_q[i-1];
            s_y[i]     = y_q[i-1];
            s_ang[i]   = ang_q[i-1];
            s_mode[i]  = mode_q[i-1];
            s_inv[i]   = inv_q[i-1];
            s_byp[i]   = byp_q[i-1];
            s_zero[i]  = zero_q[i-1];
            s_v[i]     = v_q[i-1];
            s_tag[i]   = tag_q[i-1];
            s_murec[i] = murec_q[i-1];
            s_mu[i]    = mu_q[i-1];
        end
    end

    // Micro-rotation i: choose direction, update x/y/angle, record the mu bit
    always_comb begin
        logic                    dir;
        logic                    hold;
        logic signed [ANG_W-1:0] ang_n;
        dir   = 1'b0;
        hold  = 1'b0;
        ang_n = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            x_d[i]     = s_x[i];
            y_d[i]     = s_y[i];
            ang_d[i]   = s_ang[i];
            mode_d[i]  = s_mode[i];
            inv_d[i]   = s_inv[i];
            byp_d[i]   = s_byp[i];
            zero_d[i]  = s_zero[i];
            v_d[i]     = s_v[i];
            tag_d[i]   = s_tag[i];
            murec_d[i] = s_murec[i];
            mu_d[i]    = s_mu[i];

            // Zero-input and bypassed follow beats keep x=y=ang and mu=0, so
            // their outputs land on the required values without an output mux.
            hold = s_zero[i] ||
                   (s_mode[i] != MODE_VEC && s_mode[i] != MODE_ROT && s_byp[i]);

            case (s_mode[i])
                MODE_VEC: dir = s_y[i][DATA_W-1];
                MODE_ROT: dir = ~s_ang[i][ANG_W-1];
                default:  dir = s_murec[i][i] ^ s_inv[i];
            endcase

            if (dir) begin
                ang_n = s_ang[i] - elem_ang(i);
            end else begin
                ang_n = s_ang[i] + elem_ang(i);
            end

            if (!hold) begin
                if (dir) begin
                    x_d[i] = s_x[i] - (s_y[i] >>> i);
                    y_d[i] = s_y[i] + (s_x[i] >>> i);
                end else begin
                    x_d[i] = s_x[i] + (s_y[i] >>> i);
                    y_d[i] = s_y[i] - (s_x[i] >>> i);
                end
                // Follow beats start at angle 0 and never accumulate.
                if (s_mode[i] == MODE_VEC || s_mode[i] == MODE_ROT) begin
                    ang_d[i] = ang_n;
                end
                mu_d[i][i] = dir;
            end
        end
    end

    // Pipeline registers: async clear, all stages advance together when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                ang_q[i]   <= '0;
                mode_q[i]  <= MODE_VEC;
                inv_q[i]   <= 1'b0;
                byp_q[i]   <= 1'b0;
                zero_q[i]  <= 1'b0;
                v_q[i]     <= 1'b0;
                tag_q[i]   <= '0;
                murec_q[i] <= '0;
                mu_q[i]    <= '0;
            end
        end else if (en) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                ang_q[i]   <= ang_d[i];
                mode_q[i]  <= mode_d[i];
                inv_q[i]   <= inv_d[i];
                byp_q[i]   <= byp_d[i];
                zero_q[i]  <= zero_d[i];
                v_q[i]     <= v_d[i];
                tag_q[i]   <= tag_d[i];
                murec_q[i] <= murec_d[i];
                mu_q[i]    <= mu_d[i];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_x     = x_q[STAGES-1];
    assign out_y     = y_q[STAGES-1];
    assign out_ang   = ang_q[STAGES-1];
    assign out_mu    = mu_q[STAGES-1];
    assign out_zero  = zero_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: doc/cordic_pipe_engine.md
Name: cordic_pipe_engine

Overview:
- Parametrised, fully pipelined CORDIC engine for Givens-rotation QR: one micro-rotation per registered stage.
- Three modes:
  - Vectoring: drives y to 0, accumulates the angle and records the per-stage direction bits (mu).
  - Rotation: rotates by a supplied angle.
  - Follow: replays a recorded mu vector on another row pair, optionally inverted.
- Valid/ready stream on both sides with global stall, plus a pass-through tag for the QR scheduler.

Parameters:
- DATA_W, 17, signed x/y width.
- ANG_W, 16, signed angle width (range 12..16); angle LSB = 2^-(ANG_W-2) rad, so pi/4 = 12867 at ANG_W=16.
- STAGES, 12, number of micro-rotation stages (range 4..16); stage i shifts by i.
- TAG_W, 4, width of opaque sideband tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_mode  in  2  00 vectoring, 01 rotation, 10 follow, 11 reserved (treated as follow).
- in_x, in_y  in  DATA_W  signed operands.
- in_ang  in  ANG_W  signed rotation angle (mode 01); ignored otherwise.
- in_mu  in  STAGES  recorded direction bits (mode 10); bit i drives stage i.
- in_mu_inv  in  1  follow mode: invert every mu bit (reverse rotation).
- in_bypass  in  1  follow mode: pass x/y unchanged (identity rotation).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_x, out_y  out  DATA_W  results, scaled by CORDIC gain K (1.6468 for STAGES>=8); no compensation.
- out_ang  out  ANG_W  vectoring: atan2(y,x); rotation: residual angle; follow: 0.
- out_mu  out  STAGES  mu bits used per stage.
- out_zero  out  1  vectoring beat had x==0 and y==0 on entry.
- out_tag  out  TAG_W  tag of this beat.

Behaviour:
- Reset: every stage valid, out_valid, out_x, out_y, out_ang, out_mu, out_zero and out_tag go to 0 immediately on rst_n low (async). Data registers clear; in_ready is 1 while rst_n is high and the pipeline is empty.
- Stall control:
  - en = !out_valid | out_ready; in_ready = en (combinational).
  - All stages advance together only when en is high. A beat is accepted when in_valid & in_ready.
  - Bubbles propagate as valid=0; there is no bubble collapsing.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall; throughput 1 beat/cycle.
- Stage i direction bit mu:
  - Vectoring: mu = (y<0).
  - Rotation: mu = (ang>=0).
  - Follow: mu = in_mu[i] ^ mu_inv.
- Stage i update, E_i = elementary angle:
  - mu=1: x' = x - (y>>>i), y' = y + (x>>>i), ang' = ang - E_i.
  - mu=0: x' = x + (y>>>i), y' = y - (x>>>i), ang' = ang + E_i.
  - Shifts are arithmetic, on the pre-update values of the same stage.
- Width rules: all adds wrap in two's complement with no saturation. The caller guarantees |x|,|y| < 2^(DATA_W-1)/2.4.
- Elementary angles: E_i = floor(atan(2^-i)*2^14) from a fixed 16-entry table, right-shifted by (16-ANG_W).
- Vectoring starting angle is 0.
- Quadrant: no pre-rotation. Convergence is specified for x>=0 only; x<0 produces raw iteration results with no flag.
- Zero input (vectoring, x==y==0 at entry): the zero flag travels with the beat. At output: out_ang=0, out_mu=0, out_zero=1, and out_x/out_y = 0.
- Follow with in_bypass=1: every stage passes x, y and ang unchanged; out_mu = 0; out_ang = 0.
- Follow mode output angle is forced to 0; rotation mode outputs the residual angle.
- Per-stage payload: mode, mu_inv, bypass, zero and tag ride along with the data in each stage. in_mu is registered and shifted alongside the beat.
- Simultaneous events:
  - Accept and emit in the same cycle is legal when out_ready=1.
  - An out_ready drop holds out_* stable, and in_ready drops in the same cycle.
- Reset mid-stream: all in-flight beats are discarded. The first out_valid after release comes STAGES cycles after the first post-reset acceptance.

Test Plan:
- Vectoring, STAGES=12, DATA_W=17, ANG_W=16: x=10000, y=0 -> out_x=16468±4, |out_y|<=2, |out_ang|<=8, out_mu consistent with y sign each stage, latency 12.
- Vectoring x=10000, y=10000 -> out_x=23289±6, |out_y|<=2, out_ang=12868±8; then x=10000, y=-10000 -> out_ang=-12868±8.
- Rotation x=10000, y=0, ang=12868 -> out_x=out_y=11644±6, |out_ang|<=8. Follow mode on the same x/y with the out_mu from the previous vectoring beat (x=10000, y=10000), mu_inv=1 -> identical x/y ±2.
- Zero/bypass: vectoring x=y=0 -> out_zero=1, out_ang=0, out_mu=0. Follow with bypass=1, x=-1234, y=567 -> out_x=-1234, out_y=567.
- Back-pressure: stream 20 tagged beats; hold out_ready=0 for cycles 15-19 -> in_ready low in exactly those cycles, out_* stable, all 20 tags emerge in order with no loss or duplication.
- Reset: assert rst_n low with 6 beats in flight -> out_valid=0 asynchronously and all outputs 0. After release, nothing is emitted until 12 cycles after a new acceptance.
